// File: rtl/macc_pkg.sv
// rtl/macc_pkg.sv - shared lane and product widths for the macc datapath
package macc_pkg;
   localparam int LANE_W = 8;
   localparam int PROD_W = 2 * LANE_W;
endpackage

// File: rtl/macc_adder_tree.sv
// rtl/macc_adder_tree.sv - registered pairwise adder tree with valid tracking
// Each level widens by one bit, so the sum is exact; an odd element is carried up unchanged.
module macc_adder_tree #(
   parameter int NUM_ELEMS = 9,
   parameter int IN_WIDTH = 16,
   localparam int LAYERS = $clog2(NUM_ELEMS),
   localparam int OUT_WIDTH = IN_WIDTH + LAYERS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid_i,
   input  logic [NUM_ELEMS*IN_WIDTH-1:0] in_data_i,
   output logic                          out_valid_o,
   output logic [OUT_WIDTH-1:0]          out_data_o
);

   genvar l, k;
   for (l = 0; l <= LAYERS; l++) begin : g_lvl
      localparam int CNT = (NUM_ELEMS + (1 << l) - 1) >> l;
      localparam int W = IN_WIDTH + l;
      logic signed [W-1:0] lvl_data [CNT];
      logic                lvl_valid;

      if (l == 0) begin : g_in
         assign lvl_valid = in_valid_i;
         for (k = 0; k < CNT; k++) begin : g_lane
            assign lvl_data[k] = in_data_i[k*IN_WIDTH +: IN_WIDTH];
         end
      end else begin : g_reg
         localparam int PCNT = (NUM_ELEMS + (1 << (l - 1)) - 1) >> (l - 1);
         logic signed [W-1:0] sum_d [CNT];

         for (k = 0; k < CNT; k++) begin : g_node
            logic signed [W-1:0] lo_ext;
            assign lo_ext = {g_lvl[l-1].lvl_data[2*k][W-2], g_lvl[l-1].lvl_data[2*k]};
            if (2 * k + 1 < PCNT) begin : g_add
               assign sum_d[k] = lo_ext
                  + {g_lvl[l-1].lvl_data[2*k+1][W-2], g_lvl[l-1].lvl_data[2*k+1]};
            end else begin : g_pass
               assign sum_d[k] = lo_ext;
            end
         end

         // Data only moves with a valid token, so the last result holds through bubbles.
         always_ff @(posedge clk) begin
            if (rst) begin
               lvl_valid <= 1'b0;
               lvl_data  <= '{default: '0};
            end else begin
               lvl_valid <= g_lvl[l-1].lvl_valid;
               if (g_lvl[l-1].lvl_valid) begin
                  lvl_data <= sum_d;
               end
            end
         end
      end
   end

   assign out_valid_o = g_lvl[LAYERS].lvl_valid;
   assign out_data_o  = g_lvl[LAYERS].lvl_data[0];

endmodule

// File: rtl/macc.sv
// rtl/macc.sv - pipelined signed int8 dot product: registered products feeding an adder tree
module macc
   import macc_pkg::*;
#(
   parameter int NUM_INPUTS = 9,
   localparam int ADDER_LAYERS = $clog2(NUM_INPUTS),
   localparam int OUTPUT_DATA_WIDTH = PROD_W + ADDER_LAYERS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [LANE_W*NUM_INPUTS-1:0]   i_data_a,
   input  logic [LANE_W*NUM_INPUTS-1:0]   i_data_b,
   input  logic                           i_valid,
   output logic [OUTPUT_DATA_WIDTH-1:0]   o_data,
   output logic                           o_valid
);

   logic signed [PROD_W-1:0]       prod_d [NUM_INPUTS];
   logic signed [PROD_W-1:0]       prod_q [NUM_INPUTS];
   logic                           valid0_q;
   logic [NUM_INPUTS*PROD_W-1:0]   prod_flat;

   genvar g;
   for (g = 0; g < NUM_INPUTS; g++) begin : g_mul
      logic signed [PROD_W-1:0] a_ext;
      logic signed [PROD_W-1:0] b_ext;
      // Widen before multiplying so -128 * -128 yields +16384 without wrap.
      assign a_ext = PROD_W'($signed(i_data_a[LANE_W*g +: LANE_W]));
      assign b_ext = PROD_W'($signed(i_data_b[LANE_W*g +: LANE_W]));
      assign prod_d[g] = a_ext * b_ext;
      assign prod_flat[g*PROD_W +: PROD_W] = prod_q[g];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid0_q <= 1'b0;
         prod_q   <= '{default: '0};
      end else begin
         valid0_q <= i_valid;
         if (i_valid) begin
            prod_q <= prod_d;
         end
      end
   end

   macc_adder_tree #(
      .NUM_ELEMS(NUM_INPUTS),
      .IN_WIDTH (PROD_W)
   ) u_tree (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (valid0_q),
      .in_data_i  (prod_flat),
      .out_valid_o(o_valid),
      .out_data_o (o_data)
   );

endmodule

// File: tb/tb_macc.sv
// tb/tb_macc.sv - randomized and directed self-checking bench for macc
module tb_macc;
   localparam int N   = 9;
   localparam int LAT = $clog2(N);   // edges after the sampling edge until o_valid shows
   localparam int OW  = 16 + LAT;

   logic           clk = 1'b0;
   logic           rst;
   logic [8*N-1:0] da, db;
   logic           iv;
   logic [OW-1:0]  od;
   logic           ov;

   int checks = 0;
   int failures = 0;
   int edge_n = 0;
   int last_val = 0;
   int exp_due[$];
   int exp_val[$];
   int la[N];
   int lb[N];

   always #5 clk = ~clk;

   macc #(.NUM_INPUTS(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_data_a(da),
      .i_data_b(db),
      .i_valid (iv),
      .o_data  (od),
      .o_valid (ov)
   );

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic step(input logic v, input logic r);
      int s;
      for (int i = 0; i < N; i++) begin
         da[8*i +: 8] = la[i][7:0];
         db[8*i +: 8] = lb[i][7:0];
      end
      iv  = v;
      rst = r;
      @(posedge clk);
      edge_n++;
      if (r) begin
         exp_due.delete();
         exp_val.delete();
         last_val = 0;
      end else if (v) begin
         s = 0;
         for (int i = 0; i < N; i++) s += la[i] * lb[i];
         exp_due.push_back(edge_n + LAT);
         exp_val.push_back(s);
      end
      #1;
      if (exp_due.size() > 0 && exp_due[0] == edge_n) begin
         check_val("o_valid", int'(ov), 1);
         check_val("o_data", int'($signed(od)), exp_val[0]);
         last_val = exp_val[0];
         void'(exp_due.pop_front());
         void'(exp_val.pop_front());
      end else begin
         check_val("o_valid_idle", int'(ov), 0);
         check_val("o_data_hold", int'($signed(od)), last_val);
      end
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < N; i++) begin
         la[i] = int'($urandom_range(255)) - 128;
         lb[i] = int'($urandom_range(255)) - 128;
      end
   endtask

   task automatic send_and_drain();
      step(1'b1, 1'b0);
      for (int c = 0; c < LAT + 2; c++) begin
         rand_lanes();
         step(1'b0, 1'b0);
      end
   endtask

   int av[N] = '{10, -15, 20, -25, 30, -35, 40, -45, 50};
   int bv[N] = '{-5, 10, -15, 20, -25, 30, -35, 40, -45};

   initial begin
      rand_lanes();
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);

      for (int i = 0; i < N; i++) begin la[i] = 9 - i; lb[i] = i + 1; end
      send_and_drain();
      for (int i = 0; i < N; i++) begin la[i] = -(9 - i); lb[i] = -(i + 1); end
      send_and_drain();
      for (int i = 0; i < N; i++) begin la[i] = 9 - i; lb[i] = -(9 - i); end
      send_and_drain();
      for (int j = 0; j < N; j++) begin la[8-j] = av[j]; lb[8-j] = bv[j]; end
      send_and_drain();
      for (int i = 0; i < N; i++) begin la[i] = 127; lb[i] = 127; end
      send_and_drain();
      for (int i = 0; i < N; i++) begin la[i] = -128; lb[i] = -128; end
      send_and_drain();
      for (int i = 0; i < N; i++) begin la[i] = 0; lb[i] = int'($urandom_range(255)) - 128; end
      send_and_drain();
      for (int i = 0; i < N; i++) begin la[i] = 0; lb[i] = 0; end
      la[4] = 100; lb[4] = 100;
      send_and_drain();

      for (int c = 0; c < 3; c++) begin rand_lanes(); step(1'b1, 1'b0); end
      for (int c = 0; c < LAT + 2; c++) step(1'b0, 1'b0);

      for (int c = 0; c < 300; c++) begin
         rand_lanes();
         if ($urandom_range(3) == 0) begin
            for (int i = 0; i < N; i++) la[i] = ($urandom_range(1) != 0) ? -128 : 127;
         end
         step(logic'($urandom_range(1)), 1'b0);
      end

      for (int c = 0; c < 3; c++) begin rand_lanes(); step(1'b1, 1'b0); end
      rand_lanes();
      step(1'b1, 1'b1);
      for (int c = 0; c < LAT + 3; c++) begin rand_lanes(); step(1'b0, 1'b0); end

      rand_lanes();
      send_and_drain();

      check_val("queue_empty", exp_due.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
